// File: rtl/fc_cim_arbiter_if.sv
// Bundle of everything that passes between the FC-layer requesters, the
// arbiter and the shared CIM tile group. Signal names follow the arbiter's
// point of view: i_* are arbiter inputs and o_* are arbiter outputs.
interface fc_cim_arbiter_if #(
   parameter int NUM_REQ       = 2,
   parameter int BUS_WIDTH     = 16,
   parameter int V_CIM_TILES   = 8,
   parameter int NUM_ADDR      = 64,
   parameter int NUM_ADDR_OBUF = 16
) ();
   localparam int DW      = BUS_WIDTH * V_CIM_TILES;
   localparam int ADDR_W  = $clog2(NUM_ADDR);
   localparam int OADDR_W = $clog2(NUM_ADDR_OBUF);

   // requester side
   logic [NUM_REQ-1:0]              i_req;
   logic [NUM_REQ-1:0][DW-1:0]      i_req_data;
   logic [NUM_REQ-1:0]              i_req_we;
   logic [NUM_REQ-1:0]              i_req_start;
   logic [NUM_REQ-1:0][ADDR_W-1:0]  i_req_rd_addr;
   logic [NUM_REQ-1:0][OADDR_W-1:0] i_req_obuf_addr;
   logic [NUM_REQ-1:0]              o_grant;
   logic [NUM_REQ-1:0]              o_req_cim_ready;
   logic                            o_busy;

   // tile side
   logic [DW-1:0]                   o_cim_data;
   logic                            o_cim_we;
   logic                            o_cim_start;
   logic [ADDR_W-1:0]               o_cim_rd_addr;
   logic [OADDR_W-1:0]              o_cim_obuf_addr;
   logic                            i_cim_ready;

   // arbiter view
   modport slave (
      input  i_req, i_req_data, i_req_we, i_req_start, i_req_rd_addr,
             i_req_obuf_addr, i_cim_ready,
      output o_grant, o_req_cim_ready, o_busy, o_cim_data, o_cim_we,
             o_cim_start, o_cim_rd_addr, o_cim_obuf_addr
   );

   // requesters + tiles view
   modport master (
      output i_req, i_req_data, i_req_we, i_req_start, i_req_rd_addr,
             i_req_obuf_addr, i_cim_ready,
      input  o_grant, o_req_cim_ready, o_busy, o_cim_data, o_cim_we,
             o_cim_start, o_cim_rd_addr, o_cim_obuf_addr
   );
endinterface

// File: rtl/fc_cim_arbiter.sv
// Round-robin lock arbiter sharing one CIM tile group between NUM_REQ
// FC-layer controllers. A winner keeps the tiles for its whole job; the lock
// is released only once its request is gone and the tiles report ready.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner, tile outputs all 0; arbitrate from ptr_q with wrap
// ST_GRANT | owner's data/we/start/addresses pass straight to the tiles
// ST_DRAIN | owner dropped its request, tiles still busy; we/start blocked
module fc_cim_arbiter #(
   parameter int NUM_REQ       = 2,
   parameter int BUS_WIDTH     = 16,
   parameter int V_CIM_TILES   = 8,
   parameter int NUM_ADDR      = 64,
   parameter int NUM_ADDR_OBUF = 16
) (
   input logic              clk,
   input logic              rst,
   fc_cim_arbiter_if.slave  bus
);
   localparam int DW      = BUS_WIDTH * V_CIM_TILES;
   localparam int ADDR_W  = $clog2(NUM_ADDR);
   localparam int OADDR_W = $clog2(NUM_ADDR_OBUF);
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;

   logic               found;
   logic [PTR_W-1:0]   winner;
   logic               owner_req;

   logic [DW-1:0]      mux_data;
   logic               mux_we;
   logic               mux_start;
   logic [ADDR_W-1:0]  mux_rd_addr;
   logic [OADDR_W-1:0] mux_obuf_addr;

   // Rotating search: first set request at or after ptr_q, wrapping at NUM_REQ.
   always_comb begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (!found && bus.i_req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign owner_req = |(bus.i_req & grant_q);

   // Next-state logic: lock on win, release through IDLE so there is always
   // one empty cycle between owners.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_GRANT;
               grant_d = NUM_REQ'(1) << winner;
               ptr_d   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
            end
         end
         ST_GRANT: begin
            if (!owner_req) begin
               if (bus.i_cim_ready) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // a request reasserted here is deliberately ignored
            if (bus.i_cim_ready) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // AND-OR mux off the one-hot grant; zero grant gives all-zero outputs.
   always_comb begin
      mux_data      = '0;
      mux_we        = 1'b0;
      mux_start     = 1'b0;
      mux_rd_addr   = '0;
      mux_obuf_addr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            mux_data      = mux_data      | bus.i_req_data[k];
            mux_we        = mux_we        | bus.i_req_we[k];
            mux_start     = mux_start     | bus.i_req_start[k];
            mux_rd_addr   = mux_rd_addr   | bus.i_req_rd_addr[k];
            mux_obuf_addr = mux_obuf_addr | bus.i_req_obuf_addr[k];
         end
      end
   end

   assign bus.o_grant         = grant_q;
   assign bus.o_req_cim_ready = {NUM_REQ{bus.i_cim_ready}} & grant_q;
   assign bus.o_busy          = (state_q != ST_IDLE);
   assign bus.o_cim_data      = mux_data;
   assign bus.o_cim_we        = mux_we    & (state_q == ST_GRANT);
   assign bus.o_cim_start     = mux_start & (state_q == ST_GRANT);
   assign bus.o_cim_rd_addr   = mux_rd_addr;
   assign bus.o_cim_obuf_addr = mux_obuf_addr;

endmodule

// File: tb/tb_fc_cim_arbiter.sv
// Directed bench for fc_cim_arbiter: a 2-requester instance for grant,
// masking, drain and reset behaviour, and a 3-requester instance for
// round-robin fairness. Expected grants are queued as stimulus is applied.
module tb_fc_cim_arbiter;
   localparam int BW = 16;
   localparam int VT = 8;
   localparam int NA = 64;
   localparam int NO = 16;
   localparam int DW = BW * VT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fc_cim_arbiter_if #(.NUM_REQ(2), .BUS_WIDTH(BW), .V_CIM_TILES(VT),
                       .NUM_ADDR(NA), .NUM_ADDR_OBUF(NO)) bus2 ();
   fc_cim_arbiter_if #(.NUM_REQ(3), .BUS_WIDTH(BW), .V_CIM_TILES(VT),
                       .NUM_ADDR(NA), .NUM_ADDR_OBUF(NO)) bus3 ();

   fc_cim_arbiter #(.NUM_REQ(2), .BUS_WIDTH(BW), .V_CIM_TILES(VT),
                    .NUM_ADDR(NA), .NUM_ADDR_OBUF(NO))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   fc_cim_arbiter #(.NUM_REQ(3), .BUS_WIDTH(BW), .V_CIM_TILES(VT),
                    .NUM_ADDR(NA), .NUM_ADDR_OBUF(NO))
      dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q[$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_grant(input logic [2:0] g);
      exp_q.push_back(g);
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] obs);
      logic [2:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=%0h expected=<queue empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, DW'(obs), DW'(e));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle2(input string tag);
      chk({tag, "_grant"}, DW'(bus2.o_grant), DW'(2'b00));
      chk({tag, "_busy"},  DW'(bus2.o_busy), DW'(1'b0));
      chk({tag, "_we"},    DW'(bus2.o_cim_we), DW'(1'b0));
      chk({tag, "_start"}, DW'(bus2.o_cim_start), DW'(1'b0));
      chk({tag, "_data"},  bus2.o_cim_data, DW'(0));
      chk({tag, "_rd"},    DW'(bus2.o_cim_rd_addr), DW'(0));
      chk({tag, "_obuf"},  DW'(bus2.o_cim_obuf_addr), DW'(0));
      chk({tag, "_rdy"},   DW'(bus2.o_req_cim_ready), DW'(2'b00));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [DW-1:0] DATA0 = {VT{16'h1234}};
   localparam logic [DW-1:0] DATA1 = {DW{1'b1}};

   initial begin
      int n;
      int idx;

      bus2.i_req = '0;  bus2.i_req_data = '0; bus2.i_req_we = '0;
      bus2.i_req_start = '0; bus2.i_req_rd_addr = '0; bus2.i_req_obuf_addr = '0;
      bus2.i_cim_ready = 1'b1;
      bus3.i_req = '0;  bus3.i_req_data = '0; bus3.i_req_we = '0;
      bus3.i_req_start = '0; bus3.i_req_rd_addr = '0; bus3.i_req_obuf_addr = '0;
      bus3.i_cim_ready = 1'b1;

      // reset held with both requesting: nothing may be granted
      bus2.i_req = 2'b11;
      bus2.i_req_data[0] = DATA0;   bus2.i_req_data[1] = DATA1;
      bus2.i_req_rd_addr[0] = 6'h15; bus2.i_req_rd_addr[1] = 6'h2A;
      bus2.i_req_obuf_addr[0] = 4'h3; bus2.i_req_obuf_addr[1] = 4'hC;
      bus2.i_req_we = 2'b10; bus2.i_req_start = 2'b10;
      tick(); tick();
      chk_idle2("rst");
      rst = 1'b1;

      // first arbitration: requester 0 wins, requester 1 masked
      push_grant(3'b001);
      tick();
      chk_grant("grant0_first", bus2.o_grant);
      chk("mask_we",    DW'(bus2.o_cim_we), DW'(1'b0));
      chk("mask_start", DW'(bus2.o_cim_start), DW'(1'b0));
      chk("mux_data0",  bus2.o_cim_data, DATA0);
      chk("mux_rd0",    DW'(bus2.o_cim_rd_addr), DW'(6'h15));
      chk("mux_obuf0",  DW'(bus2.o_cim_obuf_addr), DW'(4'h3));
      chk("busy_grant", DW'(bus2.o_busy), DW'(1'b1));
      chk("rdy_fan0",   DW'(bus2.o_req_cim_ready), DW'(2'b01));
      bus2.i_req_we = 2'b11; bus2.i_req_start = 2'b11;
      #1;
      chk("pass_we",    DW'(bus2.o_cim_we), DW'(1'b1));
      chk("pass_start", DW'(bus2.o_cim_start), DW'(1'b1));

      // release of 0 with ready high: one idle cycle then requester 1
      bus2.i_req = 2'b10; bus2.i_req_we = 2'b00; bus2.i_req_start = 2'b00;
      push_grant(3'b000);
      tick();
      chk_grant("release_gap", bus2.o_grant);
      chk_idle2("gap");
      push_grant(3'b010);
      tick();
      chk_grant("grant1", bus2.o_grant);
      chk("rdy_fan1",  DW'(bus2.o_req_cim_ready), DW'(2'b10));
      chk("mux_data1", bus2.o_cim_data, DATA1);
      chk("mux_rd1",   DW'(bus2.o_cim_rd_addr), DW'(6'h2A));
      bus2.i_cim_ready = 1'b0;
      #1;
      chk("rdy_fan_low", DW'(bus2.o_req_cim_ready), DW'(2'b00));
      bus2.i_cim_ready = 1'b1;

      // no preemption while 1 holds the lock
      bus2.i_req = 2'b11;
      push_grant(3'b010);
      tick();
      chk_grant("no_preempt", bus2.o_grant);
      bus2.i_req = 2'b01;
      push_grant(3'b000);
      tick();
      chk_grant("release1_gap", bus2.o_grant);
      push_grant(3'b001);
      tick();
      chk_grant("grant0_again", bus2.o_grant);

      // drain: requester 0 drops with tiles busy, still pulsing start
      bus2.i_req = 2'b10; bus2.i_cim_ready = 1'b0;
      bus2.i_req_we = 2'b01; bus2.i_req_start = 2'b01;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) bus2.i_req = 2'b11;
         push_grant(3'b001);
         tick();
         chk_grant("drain_hold", bus2.o_grant);
         chk("drain_start", DW'(bus2.o_cim_start), DW'(1'b0));
         chk("drain_we",    DW'(bus2.o_cim_we), DW'(1'b0));
         chk("drain_data",  bus2.o_cim_data, DATA0);
         chk("drain_busy",  DW'(bus2.o_busy), DW'(1'b1));
      end
      bus2.i_cim_ready = 1'b1;
      push_grant(3'b000);
      tick();
      chk_grant("drain_exit", bus2.o_grant);
      push_grant(3'b010);
      tick();
      chk_grant("after_drain_rr", bus2.o_grant);

      // hand back to 0, then async reset in the middle of its job
      bus2.i_req = 2'b01;
      push_grant(3'b000);
      tick();
      chk_grant("pre_rst_gap", bus2.o_grant);
      push_grant(3'b001);
      tick();
      chk_grant("pre_rst_grant", bus2.o_grant);
      bus2.i_req = 2'b11;
      #1;
      chk("pre_rst_start", DW'(bus2.o_cim_start), DW'(1'b1));
      #1;
      rst = 1'b0;
      #1;
      chk_idle2("async_rst");
      @(negedge clk);
      rst = 1'b1;
      push_grant(3'b001);
      tick();
      chk_grant("post_rst_grant", bus2.o_grant);
      bus2.i_req = 2'b00;
      tick(); tick();

      // fairness on the 3-requester instance
      bus3.i_req = 3'b111;
      for (int j = 0; j < 6; j++) begin
         push_grant(3'(1 << (j % 3)));
         n = 0;
         while (bus3.o_grant == 3'b000 && n < 20) begin
            tick();
            n++;
         end
         chk_grant("fair_seq", bus3.o_grant);
         idx = 0;
         for (int b = 0; b < 3; b++) if (bus3.o_grant[b]) idx = b;
         repeat (3) tick();
         bus3.i_req[idx] = 1'b0;
         tick();
         chk("fair_gap", DW'(bus3.o_grant), DW'(3'b000));
         bus3.i_req[idx] = 1'b1;
      end
      bus3.i_req = 3'b000;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
